load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 15 +
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the byte-serial load/store unit.
// Holds the FSM state encoding and the per-word beat count.
package lsu_pkg;

  localparam int BEATS = 4;
  localparam int BEAT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit.sv
// Word load/store unit serialising each access into four byte beats
// on a byte-wide data memory port with a ready handshake.
module load_store_unit #(
  parameter int MEM_ADDR_W = 32,
  parameter int BEATS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  memRead_i,
  input  logic                  memWrite_i,
  input  logic [31:0]           ALUOut_i,
  input  logic [31:0]           WriteData_i,
  output logic [31:0]           ReadData_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i,
  input  logic                  mem_ready_i
);

  import lsu_pkg::*;

  lsu_state_t state_q, state_d;

  logic                  is_wr_q;
  logic [MEM_ADDR_W-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [31:0]           shadow_q;
  logic [31:0]           rdata_q;

  logic req_ok;
  logic in_access;
  logic beat_done;
  logic last_beat;

  assign req_ok = req_valid_i
                & (memRead_i ^ memWrite_i)
                & (ALUOut_i[1:0] == 2'b00);

  assign in_access = (state_q == ACCESS);
  assign beat_done = in_access & mem_ready_i;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = req_ok ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        if (mem_ready_i && last_beat) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured once at acceptance and held per access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_wr_q  <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      beat_q   <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (state_q == IDLE && req_ok) begin
        is_wr_q <= memWrite_i;
        base_q  <= MEM_ADDR_W'(ALUOut_i);
        wdata_q <= WriteData_i;
        beat_q  <= '0;
      end
      if (beat_done) begin
        beat_q <= beat_q + 1'b1;
        if (!is_wr_q) begin
          shadow_q[8*beat_q +: 8] <= mem_rdata_i;
          if (last_beat) begin
            rdata_q <= {mem_rdata_i, shadow_q[23:0]};
          end
        end
      end
    end
  end

  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    if (in_access) begin
      mem_read_o  = ~is_wr_q;
      mem_write_o = is_wr_q;
      mem_addr_o  = base_q + MEM_ADDR_W'(beat_q);
      if (is_wr_q) begin
        mem_wdata_o = wdata_q[8*beat_q +: 8];
      end
    end
  end

  assign ReadData_o = rdata_q;
  assign done_o     = (state_q == DONE);
  assign err_o      = (state_q == ERR);
  assign stall_o    = in_access | ((state_q == IDLE) & req_valid_i);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory model, per-cycle compare,
// directed loads, stores, wait states, errors and reset mid-access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        memRead_i;
  logic        memWrite_i;
  logic [31:0] ALUOut_i;
  logic [31:0] WriteData_i;
  logic [31:0] ReadData_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ready_i;

  load_store_unit #(.MEM_ADDR_W(32), .BEATS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .memRead_i   (memRead_i),
    .memWrite_i  (memWrite_i),
    .ALUOut_i    (ALUOut_i),
    .WriteData_i (WriteData_i),
    .ReadData_o  (ReadData_o),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = -1;
  int acc_cyc = 0;
  bit chk = 1'b0;

  logic        e_stall, e_done, e_err, e_rd, e_wr;
  logic [31:0] e_addr;
  logic [7:0]  e_wdata;
  logic [31:0] e_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mem_write_o && mem_ready_i)
      mem[mem_addr_o[7:0]] <= mem_wdata_o;

  // Poison read data during wait states to catch early capture.
  assign mem_rdata_i = mem_ready_i ? mem[mem_addr_o[7:0]] : 8'h5A;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("stall", 32'(stall_o), 32'(e_stall));
      check("done", 32'(done_o), 32'(e_done));
      check("err", 32'(err_o), 32'(e_err));
      check("mrd", 32'(mem_read_o), 32'(e_rd));
      check("mwr", 32'(mem_write_o), 32'(e_wr));
      check("maddr", mem_addr_o, e_addr);
      check("mwdata", 32'(mem_wdata_o), 32'(e_wdata));
      check("rdata", ReadData_o, e_rdata);
      if (done_o) done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_idle(input logic stall);
    e_stall = stall;
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_rd    = 1'b0;
    e_wr    = 1'b0;
    e_addr  = 32'h0;
    e_wdata = 8'h00;
  endtask

  task automatic junk_req();
    req_valid_i = 1'b1;
    memRead_i   = 1'b1;
    memWrite_i  = 1'b1;
    ALUOut_i    = 32'h0000_0003;
    WriteData_i = 32'hFFFF_FFFF;
  endtask

  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] addr,
                        input logic [31:0] data,
                        input int wbeat, input int nwait);
    bit ok;
    logic [31:0] ld;
    ok = (rd ^ wr) && (addr[1:0] == 2'b00);
    ld = {mem[8'(addr + 3)], mem[8'(addr + 2)],
          mem[8'(addr + 1)], mem[addr[7:0]]};
    req_valid_i = 1'b1;
    memRead_i   = rd;
    memWrite_i  = wr;
    ALUOut_i    = addr;
    WriteData_i = data;
    mem_ready_i = 1'b1;
    exp_idle(1'b1);
    acc_cyc  = cyc;
    done_cyc = -1;
    step();
    junk_req();
    if (!ok) begin
      exp_idle(1'b0);
      e_err = 1'b1;
      step();
    end else begin
      for (int k = 0; k < 4; k++) begin
        e_stall = 1'b1;
        e_rd    = rd;
        e_wr    = wr;
        e_addr  = addr + 32'(k);
        e_wdata = wr ? data[8*k +: 8] : 8'h00;
        for (int w = 0; w < ((k == wbeat) ? nwait : 0); w++) begin
          mem_ready_i = 1'b0;
          step();
        end
        mem_ready_i = 1'b1;
        step();
      end
      exp_idle(1'b0);
      e_done = 1'b1;
      if (rd) e_rdata = ld;
      step();
    end
    req_valid_i = 1'b0;
    exp_idle(1'b0);
    step();
  endtask

  logic [7:0] orig22;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    memRead_i = 1'b0;
    memWrite_i = 1'b0;
    ALUOut_i = 32'h0;
    WriteData_i = 32'h0;
    mem_ready_i = 1'b1;
    exp_idle(1'b0);
    e_rdata = 32'h0;
    chk = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    step();

    access(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, -1, 0);
    check("st_lat", 32'(done_cyc - acc_cyc), 32'd5);
    check("st_b8", 32'(mem[8]), 32'hEF);
    check("st_b9", 32'(mem[9]), 32'hBE);
    check("st_bA", 32'(mem[10]), 32'hAD);
    check("st_bB", 32'(mem[11]), 32'hDE);

    access(1'b1, 1'b0, 32'h8, 32'h0, -1, 0);
    check("ld_lat", 32'(done_cyc - acc_cyc), 32'd5);
    check("ld_val", ReadData_o, 32'hDEAD_BEEF);

    mem[8] = 8'h11;
    mem[9] = 8'h22;
    mem[10] = 8'h33;
    mem[11] = 8'h44;
    access(1'b1, 1'b0, 32'h8, 32'h0, 1, 2);
    check("ldw_lat", 32'(done_cyc - acc_cyc), 32'd7);
    check("ldw_val", ReadData_o, 32'h4433_2211);

    access(1'b1, 1'b0, 32'h6, 32'h0, -1, 0);
    access(1'b1, 1'b1, 32'h8, 32'h0, -1, 0);
    access(1'b0, 1'b0, 32'h8, 32'h0, -1, 0);
    access(1'b0, 1'b1, 32'h9, 32'h0, -1, 0);
    check("err_keep", ReadData_o, 32'h4433_2211);
    check("err_mem", 32'(mem[9]), 32'h22);

    access(1'b0, 1'b1, 32'hF0, 32'h1234_5678, 3, 3);
    check("st2_lat", 32'(done_cyc - acc_cyc), 32'd8);
    check("st_keep", ReadData_o, 32'h4433_2211);
    access(1'b1, 1'b0, 32'hF0, 32'h0, 0, 1);
    check("ld2_val", ReadData_o, 32'h1234_5678);

    access(1'b1, 1'b0, 32'hFC, 32'h0, 2, 1);
    check("ldFC", ReadData_o,
          {8'(255*7+3), 8'(254*7+3), 8'(253*7+3), 8'(252*7+3)});

    chk = 1'b0;
    orig22 = mem[8'h22];
    req_valid_i = 1'b1;
    memRead_i = 1'b0;
    memWrite_i = 1'b1;
    ALUOut_i = 32'h20;
    WriteData_i = 32'h1122_3344;
    mem_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    step();
    step();
    check("rst_pre_wr", 32'(mem_write_o), 32'd1);
    check("rst_pre_ad", mem_addr_o, 32'h22);
    rst_i = 1'b1;
    #1;
    check("rst_wr", 32'(mem_write_o), 32'd0);
    check("rst_rd", 32'(mem_read_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_ad", mem_addr_o, 32'h0);
    check("rst_rdata", ReadData_o, 32'h0);
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_nodone", 32'(done_o), 32'd0);
      check("rst_nostb", 32'(mem_write_o), 32'd0);
    end
    check("rst_m20", 32'(mem[8'h20]), 32'h44);
    check("rst_m21", 32'(mem[8'h21]), 32'h33);
    check("rst_m22", 32'(mem[8'h22]), 32'(orig22));
    step();

    exp_idle(1'b0);
    e_rdata = 32'h0;
    chk = 1'b1;
    access(1'b1, 1'b0, 32'h20, 32'h0, -1, 0);
    check("rst_ld", ReadData_o[15:0], 32'h3344);
    chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
